// File: rtl/mmio_responder_if.sv
// Load/store bus between the core's data side and the MMIO responder.
// The core drives address, data and strobes; the responder returns load data and hit.
interface mmio_responder_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wdata;
    logic             we;
    logic             re;
    logic [DBITS-1:0] rdata;
    logic             hit;

    modport master (
        output addr, wdata, we, re,
        input  rdata, hit
    );

    modport slave (
        input  addr, wdata, we, re,
        output rdata, hit
    );
endinterface

// File: rtl/mmio_responder.sv
// MMIO responder for the 0xF0000000 window: HEX/LEDR outputs, debounced KEY/SW inputs, sticky KCTRL.
// Define MMIO_DEBOUNCE_EN to add per-bit debounce counters after the 2-FF synchronizers.
module mmio_responder #(
    parameter int               DBITS           = 32,
    parameter int               DEBOUNCE_CYCLES = 100000,
    parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110
) (
    input  logic                   clk,
    input  logic                   reset,
    mmio_responder_if.slave        bus,
    input  logic [3:0]             KEY,
    input  logic [9:0]             SW,
    output logic [9:0]             LEDR,
    output logic [6:0]             HEX0,
    output logic [6:0]             HEX1,
    output logic [6:0]             HEX2,
    output logic [6:0]             HEX3
);

    localparam int NB = 14;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [15:0]   hexval_q, hexval_d;
    logic [9:0]    ledr_q, ledr_d;
    logic [3:0]    flag_q, flag_d;
    logic          ovr_q, ovr_d;
    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] acc_q, acc_d;
    logic [NB-1:0] raw;

    logic sel_hex, sel_ledr, sel_ledg, sel_key, sel_sw, sel_kctrl;
    logic [3:0] clr_flags, rise;
    logic       clr_ovr;
    logic [DBITS-1:0] rdata_c;

    logic unused_wdata;
    assign unused_wdata = ^bus.wdata[DBITS-1:16];

    // KEY is active-low on the board; flip it so every accepted bit reads 1 = asserted.
    assign raw = {SW, ~KEY};

    assign sel_hex   = (bus.addr == ADDR_HEX);
    assign sel_ledr  = (bus.addr == ADDR_LEDR);
    assign sel_ledg  = (bus.addr == ADDR_LEDG);
    assign sel_key   = (bus.addr == ADDR_KEY);
    assign sel_sw    = (bus.addr == ADDR_SW);
    assign sel_kctrl = (bus.addr == ADDR_KCTRL);
    assign bus.hit   = sel_hex | sel_ledr | sel_ledg | sel_key | sel_sw | sel_kctrl;

`ifdef MMIO_DEBOUNCE_EN
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];

    // A bit is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != acc_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    acc_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '{default: '0};
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign acc_q = sync2_q;
    assign acc_d = sync1_q;
`endif

    // A press arriving on the same edge as its W1C clear wins and does not count as an overrun.
    always_comb begin
        hexval_d  = hexval_q;
        ledr_d    = ledr_q;
        clr_flags = '0;
        clr_ovr   = 1'b0;
        if (bus.we && sel_hex)  hexval_d = bus.wdata[15:0];
        if (bus.we && sel_ledr) ledr_d   = bus.wdata[9:0];
        if (bus.we && sel_kctrl) begin
            clr_flags = bus.wdata[3:0];
            clr_ovr   = bus.wdata[8];
        end
        rise   = acc_d[3:0] & ~acc_q[3:0];
        flag_d = (flag_q & ~clr_flags) | rise;
        ovr_d  = (ovr_q & ~clr_ovr) | (|(rise & flag_q & ~clr_flags));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hexval_q <= '0;
            ledr_q   <= '0;
            flag_q   <= '0;
            ovr_q    <= 1'b0;
            sync1_q  <= '0;
            sync2_q  <= '0;
        end else begin
            hexval_q <= hexval_d;
            ledr_q   <= ledr_d;
            flag_q   <= flag_d;
            ovr_q    <= ovr_d;
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
        end
    end

    always_comb begin
        rdata_c = '0;
        if (bus.re) begin
            if (sel_hex)   rdata_c = DBITS'(hexval_q);
            if (sel_ledr)  rdata_c = DBITS'(ledr_q);
            if (sel_key)   rdata_c = DBITS'(acc_q[3:0]);
            if (sel_sw)    rdata_c = DBITS'(acc_q[13:4]);
            if (sel_kctrl) rdata_c = DBITS'({ovr_q, 4'b0000, flag_q});
        end
    end

    assign bus.rdata = rdata_c;
    assign LEDR      = ledr_q;
    assign HEX0      = seg7(hexval_q[3:0]);
    assign HEX1      = seg7(hexval_q[7:4]);
    assign HEX2      = seg7(hexval_q[11:8]);
    assign HEX3      = seg7(hexval_q[15:12]);

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: register-map vector table plus input-path sequences.
// Expected input latency follows MMIO_DEBOUNCE_EN with DEBOUNCE_CYCLES=4.
module tb_mmio_responder;

    localparam int DB = 4;
`ifdef MMIO_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    localparam logic [31:0] A_HEX   = 32'hF0000000;
    localparam logic [31:0] A_LEDR  = 32'hF0000004;
    localparam logic [31:0] A_LEDG  = 32'hF0000008;
    localparam logic [31:0] A_KEY   = 32'hF0000010;
    localparam logic [31:0] A_SW    = 32'hF0000014;
    localparam logic [31:0] A_KCTRL = 32'hF0000110;
    localparam logic [27:0] HZ      = {4{7'b1000000}};

    logic       clk;
    logic       reset;
    logic [3:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;
    logic [6:0] hex0, hex1, hex2, hex3;

    int checks;
    int errors;

    mmio_responder_if #(.DBITS(32)) bus ();

    mmio_responder #(.DBITS(32), .DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .KEY   (key),
        .SW    (sw),
        .LEDR  (ledr),
        .HEX0  (hex0),
        .HEX1  (hex1),
        .HEX2  (hex2),
        .HEX3  (hex3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rdata;
        logic [9:0]  exp_ledr;
        logic [27:0] exp_hex;
    } vec_t;

    vec_t vecs[27];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        bus.re    = 1'b0;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.re   = 1'b1;
        bus.we   = 1'b0;
        #1;
        d = bus.rdata;
        bus.re = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        read_reg(a, d);
        check_output(name, d, exp);
    endtask

    task automatic apply_stimulus(input int i);
        bus.addr  = vecs[i].addr;
        bus.wdata = vecs[i].wdata;
        bus.we    = vecs[i].we;
        bus.re    = vecs[i].re;
        #1;
        check_output($sformatf("vec%0d_hit", i), 32'(bus.hit), 32'(vecs[i].exp_hit));
        check_output($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
        tick();
        bus.we = 1'b0;
        bus.re = 1'b0;
        check_output($sformatf("vec%0d_ledr", i), 32'(ledr), 32'(vecs[i].exp_ledr));
        check_output($sformatf("vec%0d_hex", i), 32'({hex3, hex2, hex1, hex0}), 32'(vecs[i].exp_hex));
    endtask

    initial begin
        logic [27:0] h_beef, h_1234, h_5678, h_9acd;
        checks = 0;
        errors = 0;
        h_beef = {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110};
        h_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        h_5678 = {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
        h_9acd = {7'b0010000, 7'b0001000, 7'b1000110, 7'b0100001};

        //            we    re    addr          wdata          hit   rdata          ledr     hex
        vecs[0]  = '{1'b0, 1'b1, A_HEX,        32'h0,         1'b1, 32'h0,         10'h000, HZ};
        vecs[1]  = '{1'b0, 1'b1, A_LEDR,       32'h0,         1'b1, 32'h0,         10'h000, HZ};
        vecs[2]  = '{1'b0, 1'b1, A_LEDG,       32'h0,         1'b1, 32'h0,         10'h000, HZ};
        vecs[3]  = '{1'b0, 1'b1, A_KEY,        32'h0,         1'b1, 32'h0,         10'h000, HZ};
        vecs[4]  = '{1'b0, 1'b1, A_SW,         32'h0,         1'b1, 32'h0,         10'h000, HZ};
        vecs[5]  = '{1'b0, 1'b1, A_KCTRL,      32'h0,         1'b1, 32'h0,         10'h000, HZ};
        vecs[6]  = '{1'b1, 1'b0, A_HEX,        32'hFFFFBEEF,  1'b1, 32'h0,         10'h000, h_beef};
        vecs[7]  = '{1'b1, 1'b0, A_LEDR,       32'h000003FF,  1'b1, 32'h0,         10'h3FF, h_beef};
        vecs[8]  = '{1'b0, 1'b1, A_HEX,        32'h0,         1'b1, 32'h0000BEEF,  10'h3FF, h_beef};
        vecs[9]  = '{1'b0, 1'b1, A_LEDR,       32'h0,         1'b1, 32'h000003FF,  10'h3FF, h_beef};
        vecs[10] = '{1'b1, 1'b0, 32'hF0000018, 32'h0,         1'b0, 32'h0,         10'h3FF, h_beef};
        vecs[11] = '{1'b1, 1'b0, A_LEDG,       32'h00000123,  1'b1, 32'h0,         10'h3FF, h_beef};
        vecs[12] = '{1'b0, 1'b1, A_LEDG,       32'h0,         1'b1, 32'h0,         10'h3FF, h_beef};
        vecs[13] = '{1'b1, 1'b0, A_KEY,        32'h0000000F,  1'b1, 32'h0,         10'h3FF, h_beef};
        vecs[14] = '{1'b1, 1'b0, A_SW,         32'h000003FF,  1'b1, 32'h0,         10'h3FF, h_beef};
        vecs[15] = '{1'b0, 1'b1, A_KEY,        32'h0,         1'b1, 32'h0,         10'h3FF, h_beef};
        vecs[16] = '{1'b0, 1'b1, A_SW,         32'h0,         1'b1, 32'h0,         10'h3FF, h_beef};
        vecs[17] = '{1'b0, 1'b1, 32'hF0000018, 32'h0,         1'b0, 32'h0,         10'h3FF, h_beef};
        vecs[18] = '{1'b0, 1'b0, A_HEX,        32'h0,         1'b1, 32'h0,         10'h3FF, h_beef};
        vecs[19] = '{1'b1, 1'b0, A_HEX,        32'h00001234,  1'b1, 32'h0,         10'h3FF, h_1234};
        vecs[20] = '{1'b1, 1'b0, A_HEX,        32'h00005678,  1'b1, 32'h0,         10'h3FF, h_5678};
        vecs[21] = '{1'b1, 1'b0, A_HEX,        32'h12349ACD,  1'b1, 32'h0,         10'h3FF, h_9acd};
        vecs[22] = '{1'b1, 1'b0, A_LEDR,       32'hFFFFF6A5,  1'b1, 32'h0,         10'h2A5, h_9acd};
        vecs[23] = '{1'b0, 1'b1, A_LEDR,       32'h0,         1'b1, 32'h000002A5,  10'h2A5, h_9acd};
        vecs[24] = '{1'b0, 1'b1, A_HEX,        32'h0,         1'b1, 32'h00009ACD,  10'h2A5, h_9acd};
        vecs[25] = '{1'b1, 1'b0, 32'hF000000C, 32'h0,         1'b0, 32'h0,         10'h2A5, h_9acd};
        vecs[26] = '{1'b1, 1'b0, 32'h70000004, 32'h0,         1'b0, 32'h0,         10'h2A5, h_9acd};

        reset     = 1'b1;
        key       = 4'hF;
        sw        = 10'h000;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ledr", 32'(ledr), 32'h0);
        check_output("reset_hex", 32'({hex3, hex2, hex1, hex0}), 32'(HZ));
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 27; i++) apply_stimulus(i);

        // Clean press on key0: KEY and KCTRL flag appear on the same edge.
        key = 4'b1110;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            check_reg($sformatf("press_key_e%0d", e), A_KEY, (e == LAT) ? 32'h1 : 32'h0);
            check_reg($sformatf("press_kctrl_e%0d", e), A_KCTRL, (e == LAT) ? 32'h1 : 32'h0);
        end
        key = 4'hF;
        repeat (LAT + 2) tick();
        check_reg("release_key", A_KEY, 32'h0);
        check_reg("release_kctrl_sticky", A_KCTRL, 32'h001);

        key = 4'b1110;
        repeat (LAT + 2) tick();
        check_reg("second_press_kctrl", A_KCTRL, 32'h101);
        write_reg(A_KCTRL, 32'h101);
        check_reg("w1c_kctrl", A_KCTRL, 32'h0);
        key = 4'hF;
        repeat (LAT + 2) tick();

        // Three-sample glitch on KEY[1].
        key = 4'b1101;
        repeat (3) tick();
        key = 4'hF;
        repeat (LAT + 2) tick();
        check_reg("glitch_key", A_KEY, 32'h0);
`ifdef MMIO_DEBOUNCE_EN
        check_reg("glitch_kctrl", A_KCTRL, 32'h0);
`else
        check_reg("glitch_kctrl", A_KCTRL, 32'h002);
`endif
        write_reg(A_KCTRL, 32'h10F);
        check_reg("clear_all_kctrl", A_KCTRL, 32'h0);

        // Flag0 already set, then W1C lands on the edge the next press is accepted.
        key = 4'b1110;
        repeat (LAT + 2) tick();
        key = 4'hF;
        repeat (LAT + 2) tick();
        check_reg("preset_flag0", A_KCTRL, 32'h001);
        key = 4'b1110;
        repeat (LAT - 1) tick();
        check_reg("same_edge_key_before", A_KEY, 32'h0);
        write_reg(A_KCTRL, 32'h001);
        check_reg("same_edge_key_after", A_KEY, 32'h1);
        check_reg("same_edge_kctrl", A_KCTRL, 32'h001);
        key = 4'hF;
        repeat (LAT + 2) tick();

        sw = 10'h2A5;
        repeat (LAT - 1) tick();
        check_reg("sw_before", A_SW, 32'h0);
        tick();
        check_reg("sw_after", A_SW, 32'h2A5);

        // Reset in the middle of a press: the press must restart from scratch.
        write_reg(A_KCTRL, 32'h10F);
        key = 4'b1110;
        repeat (LAT - 1) tick();
        #3;
        reset = 1'b1;
        #1;
        check_output("midreset_ledr", 32'(ledr), 32'h0);
        check_output("midreset_hex", 32'({hex3, hex2, hex1, hex0}), 32'(HZ));
        check_reg("midreset_hex_rd", A_HEX, 32'h0);
        check_reg("midreset_ledr_rd", A_LEDR, 32'h0);
        check_reg("midreset_ledg_rd", A_LEDG, 32'h0);
        check_reg("midreset_key_rd", A_KEY, 32'h0);
        check_reg("midreset_sw_rd", A_SW, 32'h0);
        check_reg("midreset_kctrl_rd", A_KCTRL, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            check_reg($sformatf("repress_key_e%0d", e), A_KEY, (e == LAT) ? 32'h1 : 32'h0);
        end
        check_reg("repress_kctrl", A_KCTRL, 32'h001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
